psum_ofifo: RTL and testbench
=============================

PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 Parameter col, default 8: number of columns; matches the column count of the upstream MAC row.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column.
REQ-003 Parameter depth, default 16: entries per column FIFO; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in  input  psum_bw*col  per-column partial sums from the MAC row; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 wr  input  col  per-column write strobe, driven by the MAC row valid outputs.
REQ-008 rd  input  1  pop request for one full row, all columns at once.
REQ-009 out  output  psum_bw*col  head entry of each column, in the same packing as in.
REQ-010 o_valid  output  1  every column FIFO is non-empty, so a full row is readable.
REQ-011 o_full  output  1  at least one column FIFO is full.
REQ-012 o_ready  output  1  inverse of o_full; used by the controller to gate execute instructions.

Function
REQ-013 Each column is an independent circular FIFO of depth entries, with a write pointer, a read pointer and an occupancy count (range 0..depth).
REQ-014 Column i write: in slice i is stored at the column's write pointer on the edge where wr[i]=1 and the column is not full.
REQ-015 Columns are written independently; the staggered valid bits from the row (one column per cycle) land in their own FIFOs without alignment logic.
REQ-016 A read is accepted on the edge where rd=1 and o_valid=1.
REQ-017 An accepted read advances every column's read pointer by one in the same cycle.
REQ-018 rd=1 while o_valid=0 is ignored: no pointer or count changes.
REQ-019 Read is first-word fall-through: out shows the head of each column combinationally from storage.
REQ-020 out is valid only while o_valid=1; its content at other times is don't-care.
REQ-021 Column write and accepted read in the same cycle:
- both take effect;
- the count is unchanged;
- this applies even when the column is full, since the pop frees the slot in the same edge.
REQ-022 Column write when full with no accepted read: the write is dropped, and the stored data and pointers are unchanged.
REQ-023 Pointers wrap from depth-1 to 0.
REQ-024 o_valid, o_full and o_ready are combinational from the counts, with no added latency.
REQ-025 Write-to-visible latency is 1 cycle: data written on edge N appears at out (if o_valid) after edge N.

Reset
REQ-026 While reset=0 at a rising edge, all pointers and counts clear to 0.
REQ-027 After that edge: o_valid=0, o_full=0, o_ready=1.
REQ-028 Storage contents are not reset.
REQ-029 Reset takes priority over a simultaneous wr or rd; in-flight data is discarded when reset asserts mid-operation.

Configuration
REQ-030 Macro PSUM_OFIFO_OVERFLOW_EN, when defined, adds output o_overflow (1 bit).
REQ-031 With the macro, o_overflow sets to 1 on the edge after any write dropped per REQ-022, stays set until reset, and reset clears it to 0.
REQ-032 Without the macro, the port and its logic are absent, and dropped writes are silent.

Verification (col=8, psum_bw=16, depth=16)
REQ-033 Release reset with no activity -> o_valid=0, o_full=0, o_ready=1 (and o_overflow=0 when the macro is defined).
REQ-034 Staggered write of 0x0011..0x0018 to columns 0..7, one column per cycle -> o_valid=1 only after the column-7 write edge; rd=1 then returns out=columns {0x0018,...,0x0011} and o_valid=0 next cycle.
REQ-035 Write all columns 16 times with no rd -> o_full=1, o_ready=0; a 17th write of 0xFFFF is dropped, the following 16 reads return the original data in order, and o_overflow=1 when the macro is defined.
REQ-036 Full FIFOs, wr=all-ones and rd=1 in the same cycle -> counts stay 16 and o_full stays 1; the head advances and the new data appears last in order.
REQ-037 rd=1 while only columns 0..6 hold data -> no change; after column 7 is written, o_valid=1.
REQ-038 reset=0 asserted after 5 rows are written -> the next cycle shows o_valid=0 and o_full=0, and subsequent writes restart at entry 0.

Source files
------------

// File: rtl/psum_ofifo_if.sv
// Row-wide partial-sum bus between the MAC row / controller and the output FIFO.
// The master side produces data and strobes; the slave side is the FIFO.
interface psum_ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready
  );
endinterface

// File: rtl/psum_ofifo.sv
// Per-column partial-sum output FIFO: independent column writes, row-wide FWFT pop.
// Optional sticky drop flag o_overflow when PSUM_OFIFO_OVERFLOW_EN is defined.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic            clk,
  input  logic            reset,
  psum_ofifo_if.slave     bus
`ifdef PSUM_OFIFO_OVERFLOW_EN
  ,
  output logic            o_overflow
`endif
);
  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] ptr_one  = aw'(1);
  localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
  localparam logic [aw:0]   cnt_full = (aw+1)'(depth);

  logic [psum_bw-1:0] mem  [col][depth];
  logic [aw-1:0]      wptr [col];
  logic [aw-1:0]      rptr [col];
  logic [aw:0]        cnt  [col];

  logic [col-1:0] nonempty;
  logic [col-1:0] full;
  logic [col-1:0] wr_acc;
  logic           rd_acc;

  // A full column still accepts a write when the row pop frees its head slot.
  always_comb begin
    nonempty = '0;
    full     = '0;
    wr_acc   = '0;
    for (int i = 0; i < col; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == cnt_full);
    end
    rd_acc = bus.rd & (&nonempty);
    for (int i = 0; i < col; i++) begin
      wr_acc[i] = bus.wr[i] & (~full[i] | rd_acc);
    end
  end

  assign bus.o_valid = &nonempty;
  assign bus.o_full  = |full;
  assign bus.o_ready = ~(|full);

  for (genvar g = 0; g < col; g++) begin : g_out
    assign bus.out[psum_bw*g +: psum_bw] = mem[g][rptr[g]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (reset && wr_acc[i]) begin
        mem[i][wptr[i]] <= bus.in[psum_bw*i +: psum_bw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < col; i++) begin
        if (wr_acc[i]) wptr[i] <= wptr[i] + ptr_one;
        if (rd_acc)    rptr[i] <= rptr[i] + ptr_one;
        case ({wr_acc[i], rd_acc})
          2'b10:   cnt[i] <= cnt[i] + cnt_one;
          2'b01:   cnt[i] <= cnt[i] - cnt_one;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

`ifdef PSUM_OFIFO_OVERFLOW_EN
  logic drop;
  assign drop = |(bus.wr & full & ~{col{rd_acc}});

  always_ff @(posedge clk) begin
    if (!reset)    o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized self-checking bench for psum_ofifo against a queue-per-column model.
module tb_psum_ofifo;
  localparam int ncol = 8;
  localparam int bw   = 16;
  localparam int dep  = 16;

  logic clk = 1'b0;
  logic reset;
`ifdef PSUM_OFIFO_OVERFLOW_EN
  logic o_overflow;
`endif

  psum_ofifo_if #(.col(ncol), .psum_bw(bw)) bus ();

  psum_ofifo #(.col(ncol), .psum_bw(bw), .depth(dep)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PSUM_OFIFO_OVERFLOW_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [bw-1:0] q [ncol][$];
  logic          m_ovf;

  function automatic logic m_valid();
    for (int i = 0; i < ncol; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < ncol; i++) if (q[i].size() == dep) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [bw*ncol-1:0] m_out();
    logic [bw*ncol-1:0] r = '0;
    for (int i = 0; i < ncol; i++) if (q[i].size() != 0) r[bw*i +: bw] = q[i][0];
    return r;
  endfunction

  function automatic logic [bw*ncol-1:0] rand_row();
    logic [bw*ncol-1:0] r;
    for (int i = 0; i < ncol; i++) r[bw*i +: bw] = bw'($urandom);
    return r;
  endfunction

  // Apply one cycle of stimulus, update the model from the spec rules, settle past the edge.
  task automatic drive(input logic [ncol-1:0] w, input logic r, input logic [bw*ncol-1:0] d);
    logic acc;
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    acc = r && m_valid();
    @(posedge clk);
    for (int i = 0; i < ncol; i++) begin
      if (w[i] && q[i].size() == dep && !acc) m_ovf = 1'b1;
      if (acc) void'(q[i].pop_front());
      if (w[i] && q[i].size() < dep) q[i].push_back(d[bw*i +: bw]);
    end
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    @(posedge clk);
    for (int i = 0; i < ncol; i++) q[i].delete();
    m_ovf = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, 1'b0, '0);
    vectors++;
    if ({bus.o_valid, bus.o_full, bus.o_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags got v/f/r=%b%b%b want 001", bus.o_valid, bus.o_full, bus.o_ready);
    end
`ifdef PSUM_OFIFO_OVERFLOW_EN
    vectors++;
    if (o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf got %b want 0", o_overflow);
    end
`endif
  endtask

  task automatic test_stagger();
    logic [bw*ncol-1:0] d;
    do_reset();
    for (int c = 0; c < ncol; c++) begin
      d = rand_row();
      d[bw*c +: bw] = bw'(16'h0011 + c);
      drive(ncol'(1) << c, 1'b0, d);
      vectors++;
      if (bus.o_valid !== (c == ncol-1)) begin
        miscompares++;
        $display("FAIL stagger_valid col%0d got %b want %b", c, bus.o_valid, (c == ncol-1));
      end
    end
    vectors++;
    if (bus.out !== 128'h0018_0017_0016_0015_0014_0013_0012_0011) begin
      miscompares++;
      $display("FAIL stagger_out got %h want 00180017001600150014001300120011", bus.out);
    end
    drive('0, 1'b1, '0);
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stagger_pop_valid got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int k = 0; k < dep; k++) drive('1, 1'b0, rand_row());
    vectors++;
    if ({bus.o_full, bus.o_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_flags got f/r=%b%b want 10", bus.o_full, bus.o_ready);
    end
    drive('1, 1'b0, {ncol{16'hFFFF}});
`ifdef PSUM_OFIFO_OVERFLOW_EN
    vectors++;
    if (o_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag got %b want 1", o_overflow);
    end
`endif
    for (int k = 0; k < dep; k++) begin
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.out !== m_out()) begin
        miscompares++;
        $display("FAIL full_drain%0d got v=%b %h want v=1 %h", k, bus.o_valid, bus.out, m_out());
      end
      drive('0, 1'b1, '0);
    end
    vectors++;
    if ({bus.o_valid, bus.o_full} !== 2'b00) begin
      miscompares++;
      $display("FAIL full_empty got v/f=%b%b want 00", bus.o_valid, bus.o_full);
    end
  endtask

  task automatic test_full_rw();
    logic [bw*ncol-1:0] nd;
    do_reset();
    for (int k = 0; k < dep; k++) drive('1, 1'b0, rand_row());
    nd = rand_row();
    drive('1, 1'b1, nd);
    vectors++;
    if (bus.o_full !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_full got %b want 1", bus.o_full);
    end
`ifdef PSUM_OFIFO_OVERFLOW_EN
    vectors++;
    if (o_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_no_ovf got %b want 0", o_overflow);
    end
`endif
    for (int k = 0; k < dep; k++) begin
      vectors++;
      if (bus.out !== m_out()) begin
        miscompares++;
        $display("FAIL rw_drain%0d got %h want %h", k, bus.out, m_out());
      end
      if (k == dep-1) begin
        vectors++;
        if (bus.out !== nd) begin
          miscompares++;
          $display("FAIL rw_last got %h want %h", bus.out, nd);
        end
      end
      drive('0, 1'b1, '0);
    end
  endtask

  task automatic test_rd_ignored();
    logic [bw*ncol-1:0] d;
    do_reset();
    d = rand_row();
    drive(8'h7F, 1'b0, d);
    drive('0, 1'b1, '0);
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdign_valid got %b want 0", bus.o_valid);
    end
    drive(8'h80, 1'b0, d);
    vectors++;
    if (bus.o_valid !== 1'b1 || bus.out !== d) begin
      miscompares++;
      $display("FAIL rdign_row got v=%b %h want v=1 %h", bus.o_valid, bus.out, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [bw*ncol-1:0] d;
    do_reset();
    for (int k = 0; k < 5; k++) drive('1, 1'b0, rand_row());
    do_reset();
    vectors++;
    if ({bus.o_valid, bus.o_full} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_flags got v/f=%b%b want 00", bus.o_valid, bus.o_full);
    end
    d = rand_row();
    drive('1, 1'b0, d);
    vectors++;
    if (bus.out !== d) begin
      miscompares++;
      $display("FAIL rstmid_restart got %h want %h", bus.out, d);
    end
  endtask

  task automatic test_random();
    logic [ncol-1:0] w;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      w = ncol'($urandom);
      drive(w, ($urandom_range(0, 99) < ((k / 150) % 2 == 0 ? 25 : 70)), rand_row());
      vectors++;
      if (bus.o_valid !== m_valid() || bus.o_full !== m_full() || bus.o_ready !== !m_full()
          || (m_valid() && bus.out !== m_out())) begin
        miscompares++;
        $display("FAIL random%0d got v/f/r=%b%b%b %h want %b%b%b %h", k, bus.o_valid,
                 bus.o_full, bus.o_ready, bus.out, m_valid(), m_full(), !m_full(), m_out());
      end
`ifdef PSUM_OFIFO_OVERFLOW_EN
      vectors++;
      if (o_overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL random_ovf%0d got %b want %b", k, o_overflow, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_full_overflow();
    test_full_rw();
    test_rd_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
